// File: rtl/yolo_wr_pkg.sv
// Shared types and sizing for the YOLO write packer: FSM states,
// the beat entry carried through the FIFO, and derived widths.
package yolo_wr_pkg;

    localparam int DATA_W     = 32;
    localparam int PACK       = 2;
    localparam int ADDR_W     = 32;
    localparam int LEN_W      = 16;
    localparam int FIFO_DEPTH = 4;

    // Lane index width; a single-lane packer still needs a 1-bit counter.
    localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [PACK*DATA_W-1:0] data;
        logic [PACK-1:0]        strb;
        logic [ADDR_W-1:0]      addr;
        logic                   last;
    } wr_entry_t;

endpackage

// File: rtl/yolo_wr_packer_if.sv
// Result-word input and addressed memory-write port of the packer.
// master: the packer side; slave: the producer/memory side.
interface yolo_wr_packer_if;
    import yolo_wr_pkg::*;

    logic                   in_valid;
    logic [DATA_W-1:0]      in_data;
    logic                   m_valid;
    logic                   m_ready;
    logic [ADDR_W-1:0]      m_addr;
    logic [PACK*DATA_W-1:0] m_data;
    logic [PACK-1:0]        m_strb;
    logic                   m_last;

    modport master (
        input  in_valid, in_data, m_ready,
        output m_valid, m_addr, m_data, m_strb, m_last
    );

    modport slave (
        output in_valid, in_data, m_ready,
        input  m_valid, m_addr, m_data, m_strb, m_last
    );

endinterface

// File: rtl/yolo_wr_fifo.sv
// Beat FIFO: circular buffer of entries, head presented straight from
// storage flops (zeroed while empty). A push into a full FIFO is only
// accepted when a pop happens on the same edge; otherwise it is dropped.
module yolo_wr_fifo
    import yolo_wr_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  wr_entry_t        push_entry,
    input  logic             pop,
    output wr_entry_t        head,
    output logic             head_valid,
    output logic             full,
    output logic             drop,
    output logic [CNT_W-1:0] level
);

    wr_entry_t        mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign head_valid = (level != '0);
    assign full       = (level == CNT_W'(FIFO_DEPTH));
    assign rd_en      = pop && head_valid;
    assign wr_en      = push && (!full || rd_en);
    assign drop       = push && full && !rd_en;
    assign head       = head_valid ? mem[rd_ptr] : '0;

    // Storage write.
    // NOTE: the data array has no reset; validity comes only from level, so
    // stale entries are never visible and the array can map to plain flops/RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointer and occupancy tracking.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register in the design samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level + CNT_W'(wr_en) - CNT_W'(rd_en);
        end
    end

endmodule

// File: rtl/yolo_wr_packer.sv
// Packs PACK result words from the YOLO conv/pool unit into one wide beat,
// buffers beats in a small FIFO and writes them to consecutive beat
// addresses. The producer cannot be stalled: beats that find the FIFO full
// are dropped and flagged in the sticky ovf bit.
module yolo_wr_packer
    import yolo_wr_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [LEN_W-1:0]  cfg_len,
    yolo_wr_packer_if.master  bus,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    state_t                 state;
    logic [ADDR_W-1:0]      base_q;
    logic [LEN_W-1:0]       len_q;
    logic [LEN_W-1:0]       word_cnt;
    logic [ADDR_W-1:0]      beat_cnt;
    logic [LANE_W-1:0]      lane_cnt;
    logic [PACK*DATA_W-1:0] pack_data;
    logic [PACK-1:0]        pack_strb;

    logic [PACK*DATA_W-1:0] next_data;
    logic [PACK-1:0]        next_strb;
    logic                   final_word;
    logic                   beat_full;
    logic                   push;
    logic                   pop;
    wr_entry_t              push_entry;
    wr_entry_t              head;
    logic                   head_valid;
    logic                   fifo_full;
    logic                   fifo_drop;
    logic [CNT_W-1:0]       fifo_level;

    // Beat under construction with the incoming word merged into its lane.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        next_data = pack_data;
        next_data[int'(lane_cnt)*DATA_W +: DATA_W] = bus.in_data;
        next_strb  = pack_strb | (PACK'(1) << lane_cnt);
        final_word = (word_cnt == len_q - LEN_W'(1));
        beat_full  = (lane_cnt == LANE_W'(PACK - 1));
        push       = (state == ST_RUN) && bus.in_valid && (beat_full || final_word);
        push_entry = '{data: next_data,
                       strb: next_strb,
                       addr: base_q + beat_cnt,
                       last: final_word};
    end

    assign pop = head_valid && bus.m_ready;

    yolo_wr_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .head_valid (head_valid),
        .full       (fifo_full),
        .drop       (fifo_drop),
        .level      (fifo_level)
    );

    assign bus.m_valid = head_valid;
    assign bus.m_addr  = head.addr;
    assign bus.m_data  = head.data;
    assign bus.m_strb  = head.strb;
    assign bus.m_last  = head.last;

    // Run control FSM with packing counters and registered busy/done/ovf.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            word_cnt  <= '0;
            beat_cnt  <= '0;
            lane_cnt  <= '0;
            pack_data <= '0;
            pack_strb <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        base_q    <= cfg_base;
                        len_q     <= cfg_len;
                        word_cnt  <= '0;
                        beat_cnt  <= '0;
                        lane_cnt  <= '0;
                        pack_data <= '0;
                        pack_strb <= '0;
                        ovf       <= 1'b0;
                        if (cfg_len == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.in_valid) begin
                        word_cnt <= word_cnt + LEN_W'(1);
                        if (beat_full || final_word) begin
                            pack_data <= '0;
                            pack_strb <= '0;
                            lane_cnt  <= '0;
                            beat_cnt  <= beat_cnt + ADDR_W'(1);
                        end else begin
                            pack_data <= next_data;
                            pack_strb <= next_strb;
                            lane_cnt  <= lane_cnt + LANE_W'(1);
                        end
                        if (fifo_drop) begin
                            ovf <= 1'b1;
                        end
                        if (final_word) begin
                            state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    // Leave as soon as the FIFO is (or is about to be) empty;
                    // a dropped final beat simply ends the run on drain.
                    if (!head_valid || (fifo_level == CNT_W'(1) && pop)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_yolo_wr_packer.sv
// Directed bench for yolo_wr_packer: a table of complete runs with
// hand-computed beats, plus sequences for backpressure, overflow,
// zero-length runs, run-while-busy and reset in the middle of a run.
module tb_yolo_wr_packer;
    import yolo_wr_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              run = 1'b0;
    logic [ADDR_W-1:0] cfg_base = '0;
    logic [LEN_W-1:0]  cfg_len = '0;
    logic              busy;
    logic              done;
    logic              ovf;

    yolo_wr_packer_if bus ();

    yolo_wr_packer dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .cfg_base (cfg_base),
        .cfg_len  (cfg_len),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0]      addr;
        logic [PACK*DATA_W-1:0] data;
        logic [PACK-1:0]        strb;
        logic                   last;
    } beat_t;

    typedef struct {
        logic [ADDR_W-1:0]           base;
        int                          len;
        logic [3:0][DATA_W-1:0]      words;
        int                          n_beats;
        beat_t [1:0]                 exp;
    } vec_t;

    vec_t  vecs [8];
    int    nv = 0;
    beat_t cap_q [$];
    int    done_cnt = 0;
    int    checks = 0;
    int    errors = 0;

    // Record every beat handshake and every done pulse (sampled mid-cycle).
    always @(negedge clk) begin
        if (rst) begin
            if (bus.m_valid && bus.m_ready) begin
                cap_q.push_back(beat_t'{bus.m_addr, bus.m_data, bus.m_strb, bus.m_last});
            end
            if (done) begin
                done_cnt++;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len);
        cfg_base = base;
        cfg_len  = len;
        run      = 1'b1;
        tick();
        run      = 1'b0;
    endtask

    task automatic feed(input logic [DATA_W-1:0] w);
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 200);
        check({tag, "_done_seen"}, done, 1'b1);
        check({tag, "_busy_low_at_done"}, busy, 1'b0);
    endtask

    task automatic add_vec(input logic [ADDR_W-1:0] base, input int len,
                           input logic [DATA_W-1:0] w0, input logic [DATA_W-1:0] w1,
                           input logic [DATA_W-1:0] w2, input logic [DATA_W-1:0] w3,
                           input int n_beats, input beat_t e0, input beat_t e1);
        vecs[nv].base     = base;
        vecs[nv].len      = len;
        vecs[nv].words[0] = w0;
        vecs[nv].words[1] = w1;
        vecs[nv].words[2] = w2;
        vecs[nv].words[3] = w3;
        vecs[nv].n_beats  = n_beats;
        vecs[nv].exp[0]   = e0;
        vecs[nv].exp[1]   = e1;
        nv++;
    endtask

    task automatic do_vec(input int i);
        string tag;
        tag = $sformatf("vec%0d", i);
        cap_q.delete();
        done_cnt     = 0;
        bus.m_ready  = 1'b1;
        start_run(vecs[i].base, LEN_W'(vecs[i].len));
        check({tag, "_busy"}, busy, 1'b1);
        check({tag, "_ovf_cleared"}, ovf, 1'b0);
        for (int w = 0; w < vecs[i].len; w++) begin
            feed(vecs[i].words[w]);
        end
        wait_done(tag);
        tick();
        tick();
        check({tag, "_beats"}, 64'(cap_q.size()), 64'(vecs[i].n_beats));
        for (int b = 0; b < vecs[i].n_beats && b < cap_q.size(); b++) begin
            check($sformatf("%s_b%0d_addr", tag, b), cap_q[b].addr, vecs[i].exp[b].addr);
            check($sformatf("%s_b%0d_data", tag, b), cap_q[b].data, vecs[i].exp[b].data);
            check($sformatf("%s_b%0d_strb", tag, b), cap_q[b].strb, vecs[i].exp[b].strb);
            check($sformatf("%s_b%0d_last", tag, b), cap_q[b].last, vecs[i].exp[b].last);
        end
        check({tag, "_done_once"}, 64'(done_cnt), 64'd1);
        check({tag, "_busy_after"}, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.m_ready  = 1'b1;

        add_vec(32'h0000_0100, 4, 32'd1, 32'd2, 32'd3, 32'd4, 2,
                beat_t'{32'h0000_0100, 64'h00000002_00000001, 2'b11, 1'b0},
                beat_t'{32'h0000_0101, 64'h00000004_00000003, 2'b11, 1'b1});
        add_vec(32'h0000_0200, 3, 32'hA, 32'hB, 32'hC, 32'h0, 2,
                beat_t'{32'h0000_0200, 64'h0000000B_0000000A, 2'b11, 1'b0},
                beat_t'{32'h0000_0201, 64'h00000000_0000000C, 2'b01, 1'b1});
        add_vec(32'hFFFF_FFFF, 4, 32'd5, 32'd6, 32'd7, 32'd8, 2,
                beat_t'{32'hFFFF_FFFF, 64'h00000006_00000005, 2'b11, 1'b0},
                beat_t'{32'h0000_0000, 64'h00000008_00000007, 2'b11, 1'b1});
        add_vec(32'h0000_0040, 1, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 1,
                beat_t'{32'h0000_0040, 64'h00000000_DEADBEEF, 2'b01, 1'b1}, '0);
        add_vec(32'h0000_0010, 2, 32'h11, 32'h22, 32'h0, 32'h0, 1,
                beat_t'{32'h0000_0010, 64'h00000022_00000011, 2'b11, 1'b1}, '0);

        // Reset state.
        tick();
        check("rst_m_valid", bus.m_valid, 1'b0);
        check("rst_m_addr", bus.m_addr, '0);
        check("rst_m_data", bus.m_data, '0);
        check("rst_m_strb", bus.m_strb, '0);
        check("rst_m_last", bus.m_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        rst = 1'b1;
        tick();

        // Words while idle are ignored.
        feed(32'hBAD0_0BAD);
        tick();
        check("idle_word_ignored", bus.m_valid, 1'b0);

        // Overflow: 6 beats into a 4-deep FIFO with the memory stalled.
        cap_q.delete();
        done_cnt    = 0;
        bus.m_ready = 1'b0;
        start_run(32'h0000_0400, LEN_W'(12));
        for (int w = 1; w <= 12; w++) begin
            feed(DATA_W'(w));
            if (w == 8) check("ovf_clear_at_4_beats", ovf, 1'b0);
            if (w == 10) check("ovf_set_at_5th_beat", ovf, 1'b1);
        end
        check("ovf_busy_stalled", busy, 1'b1);
        check("ovf_head_addr", bus.m_addr, 32'h0000_0400);
        bus.m_ready = 1'b1;
        wait_done("ovf");
        tick();
        tick();
        check("ovf_beats", 64'(cap_q.size()), 64'd4);
        for (int b = 0; b < 4 && b < cap_q.size(); b++) begin
            check($sformatf("ovf_b%0d_addr", b), cap_q[b].addr, 32'h0000_0400 + ADDR_W'(b));
            check($sformatf("ovf_b%0d_data", b), cap_q[b].data,
                  {DATA_W'(2 * b + 2), DATA_W'(2 * b + 1)});
            check($sformatf("ovf_b%0d_last", b), cap_q[b].last, 1'b0);
        end
        check("ovf_done_once", 64'(done_cnt), 64'd1);
        check("ovf_sticky", ovf, 1'b1);

        // Table of complete runs (first one also shows ovf cleared on run).
        for (int i = 0; i < nv; i++) begin
            do_vec(i);
        end

        // Backpressure: beat held stable for 10 cycles, extra word in FLUSH ignored.
        cap_q.delete();
        done_cnt    = 0;
        bus.m_ready = 1'b0;
        start_run(32'h0000_0300, LEN_W'(4));
        feed(32'h31);
        check("bp_no_beat_after_w1", bus.m_valid, 1'b0);
        feed(32'h32);
        check("bp_beat_latency", bus.m_valid, 1'b1);
        feed(32'h33);
        feed(32'h34);
        feed(32'hEEEE);
        for (int c = 0; c < 10; c++) begin
            check($sformatf("bp_hold%0d_valid", c), bus.m_valid, 1'b1);
            check($sformatf("bp_hold%0d_addr", c), bus.m_addr, 32'h0000_0300);
            check($sformatf("bp_hold%0d_data", c), bus.m_data, 64'h00000032_00000031);
            tick();
        end
        check("bp_ovf", ovf, 1'b0);
        bus.m_ready = 1'b1;
        wait_done("bp");
        tick();
        check("bp_beats", 64'(cap_q.size()), 64'd2);
        if (cap_q.size() == 2) begin
            check("bp_b1_addr", cap_q[1].addr, 32'h0000_0301);
            check("bp_b1_data", cap_q[1].data, 64'h00000034_00000033);
            check("bp_b1_last", cap_q[1].last, 1'b1);
        end

        // Zero-length run: done the cycle after run, no beat.
        done_cnt = 0;
        start_run(32'h0000_0700, LEN_W'(0));
        @(negedge clk);
        check("len0_done", done, 1'b1);
        check("len0_busy", busy, 1'b0);
        check("len0_no_valid", bus.m_valid, 1'b0);
        tick();
        @(negedge clk);
        check("len0_done_drop", done, 1'b0);
        check("len0_done_once", 64'(done_cnt), 64'd1);

        // run held high through the whole run, including the DONE cycle.
        cap_q.delete();
        done_cnt = 0;
        cfg_base = 32'h0000_0500;
        cfg_len  = LEN_W'(2);
        run      = 1'b1;
        tick();
        check("rb_busy", busy, 1'b1);
        cfg_base = 32'h0000_0999;
        cfg_len  = LEN_W'(0);
        feed(32'h51);
        feed(32'h52);
        wait_done("rb");
        tick();
        run = 1'b0;
        tick();
        tick();
        check("rb_busy_after", busy, 1'b0);
        check("rb_done_once", 64'(done_cnt), 64'd1);
        check("rb_beats", 64'(cap_q.size()), 64'd1);
        if (cap_q.size() == 1) begin
            check("rb_b0_addr", cap_q[0].addr, 32'h0000_0500);
            check("rb_b0_data", cap_q[0].data, 64'h00000052_00000051);
        end

        // Reset in the middle of a run, then a fresh run.
        bus.m_ready = 1'b0;
        start_run(32'h0000_0600, LEN_W'(4));
        feed(32'h61);
        feed(32'h62);
        check("mid_beat_issued", bus.m_valid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_m_valid", bus.m_valid, 1'b0);
        check("mid_rst_m_data", bus.m_data, '0);
        check("mid_rst_m_addr", bus.m_addr, '0);
        check("mid_rst_m_strb", bus.m_strb, '0);
        check("mid_rst_m_last", bus.m_last, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        tick();
        rst = 1'b1;
        bus.m_ready = 1'b1;
        tick();
        check("post_rst_no_valid", bus.m_valid, 1'b0);
        do_vec(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
